// File: rtl/hash_pkg.sv
// hash_pkg: fill-state encoding, per-algorithm default widths and a counter
// width helper shared by the hash host interface files.
package hash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2
    } fill_state_t;

    // ECHO defaults: 16-bit host bus, 1536-bit block, 256-bit digest.
    localparam int ECHO_BUS_W   = 16;
    localparam int ECHO_BLOCK_W = 1536;
    localparam int ECHO_HASH_W  = 256;

    // Width of an index counter over n words; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hash_host_rd.sv
// hash_host_rd: digest capture register and fetch serialiser.
// The captured digest sits in a shift register whose top word is always the
// next word to hand out, so no variable indexing is needed.
module hash_host_rd
    import hash_pkg::*;
#(
    parameter int BUS_W  = ECHO_BUS_W,
    parameter int HASH_W = ECHO_HASH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              fetch_go,
    input  logic              core_done,
    input  logic [HASH_W-1:0] core_hash,
    output logic              hash_valid,
    output logic [BUS_W-1:0]  odata
);

    localparam int              WPH     = HASH_W / BUS_W;
    localparam int              RD_W    = cnt_w(WPH);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(WPH - 1);

    logic [HASH_W-1:0] hash_sr;
    logic [RD_W-1:0]   rd_cnt;

    // Capture on core_done, shift out one word per accepted fetch. A digest
    // arriving with an accepted fetch replaces the old one, while the word
    // being acked still comes from the old digest.
    always_ff @(posedge clk) begin
        if (rst) begin
            hash_sr    <= '0;
            rd_cnt     <= '0;
            hash_valid <= 1'b0;
            odata      <= '0;
        end else begin
            if (fetch_go) begin
                odata <= hash_sr[HASH_W-1 -: BUS_W];
            end
            if (clr) begin
                rd_cnt     <= '0;
                hash_valid <= 1'b0;
            end else if (core_done) begin
                hash_sr    <= core_hash;
                rd_cnt     <= '0;
                hash_valid <= 1'b1;
            end else if (fetch_go) begin
                hash_sr <= hash_sr << BUS_W;
                if (rd_cnt == RD_LAST) begin
                    rd_cnt     <= '0;
                    hash_valid <= 1'b0;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hash_host_if.sv
// hash_host_if: host word interface for the hash cores. Assembles BUS_W-bit
// words (MSW first) into BLOCK_W-bit blocks for the core and serialises the
// digest back to the host through hash_host_rd.
// Build option HASH_HOST_IF_DBUF_EN: adds a separate fill buffer so the next
// block can be loaded while the core is still compressing.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, no message open; loads are not acked
// FILL  | accepting message words into the fill register
// ISSUE | full block waiting for the core to go idle before core_start
module hash_host_if
    import hash_pkg::*;
#(
    parameter int BUS_W   = ECHO_BUS_W,
    parameter int BLOCK_W = ECHO_BLOCK_W,
    parameter int HASH_W  = ECHO_HASH_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               load,
    input  logic               fetch,
    input  logic [BUS_W-1:0]   idata,
    output logic [BUS_W-1:0]   odata,
    output logic               ack,
    output logic               core_init,
    output logic               core_start,
    output logic [BLOCK_W-1:0] core_blk,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [HASH_W-1:0]  core_hash
);

    localparam int              WPB     = BLOCK_W / BUS_W;
    localparam int              WR_W    = cnt_w(WPB);
    localparam logic [WR_W-1:0] WR_LAST = WR_W'(WPB - 1);

    fill_state_t     state;
    logic [WR_W-1:0] wr_cnt;
    logic            hash_valid;
    logic            fill_open;
    logic            load_go;
    logic            fetch_go;

`ifdef HASH_HOST_IF_DBUF_EN
    logic [BLOCK_W-1:0] fill_buf;

    assign fill_open = (state == FILL);

    // Fill buffer: words shift in at the LSB end, so the first word ends at the MSW.
    always_ff @(posedge clk) begin
        if (load_go) begin
            fill_buf <= {fill_buf[BLOCK_W-BUS_W-1:0], idata};
        end
    end
`else
    // core_blk doubles as the fill register, so it must not change under a busy core.
    assign fill_open = (state == FILL) && !core_busy;
`endif

    // init beats load beats fetch; nothing is accepted during an ack cycle.
    assign load_go  = load && !ack && !init && fill_open;
    assign fetch_go = fetch && !ack && !init && !load_go && hash_valid;

    // Fill FSM with registered ack / core_init / core_start / core_blk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            ack        <= 1'b0;
            core_init  <= 1'b0;
            core_start <= 1'b0;
            core_blk   <= '0;
        end else begin
            ack        <= load_go || fetch_go;
            core_init  <= init;
            core_start <= 1'b0;
            if (init) begin
                state  <= FILL;
                wr_cnt <= '0;
            end else begin
                case (state)
                    FILL: begin
                        if (load_go) begin
`ifndef HASH_HOST_IF_DBUF_EN
                            core_blk <= {core_blk[BLOCK_W-BUS_W-1:0], idata};
`endif
                            if (wr_cnt == WR_LAST) begin
                                wr_cnt <= '0;
                                // An idle core takes the block straight away so
                                // core_start lines up with the last word's ack.
                                if (core_busy) begin
                                    state <= ISSUE;
                                end else begin
                                    core_start <= 1'b1;
`ifdef HASH_HOST_IF_DBUF_EN
                                    core_blk <= {fill_buf[BLOCK_W-BUS_W-1:0], idata};
`endif
                                end
                            end else begin
                                wr_cnt <= wr_cnt + 1'b1;
                            end
                        end
                    end
                    ISSUE: begin
                        if (!core_busy) begin
`ifdef HASH_HOST_IF_DBUF_EN
                            core_blk <= fill_buf;
`endif
                            core_start <= 1'b1;
                            state      <= FILL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    hash_host_rd #(
        .BUS_W  (BUS_W),
        .HASH_W (HASH_W)
    ) u_rd (
        .clk        (clk),
        .rst        (rst),
        .clr        (init),
        .fetch_go   (fetch_go),
        .core_done  (core_done),
        .core_hash  (core_hash),
        .hash_valid (hash_valid),
        .odata      (odata)
    );

endmodule

// File: tb/tb_hash_host_if.sv
// tb_hash_host_if: randomized bench for hash_host_if with a scoreboard.
// Drivers push expected acks/blocks into queues; a negedge monitor pops and
// compares whenever the DUT raises ack or core_start.
`timescale 1ns/1ps
module tb_hash_host_if;

    localparam int BUS_W   = 16;
    localparam int BLOCK_W = 1536;
    localparam int HASH_W  = 256;
    localparam int WPB     = BLOCK_W / BUS_W;
    localparam int WPH     = HASH_W / BUS_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               init = 1'b0;
    logic               load = 1'b0;
    logic               fetch = 1'b0;
    logic [BUS_W-1:0]   idata = '0;
    logic [BUS_W-1:0]   odata;
    logic               ack;
    logic               core_init;
    logic               core_start;
    logic [BLOCK_W-1:0] core_blk;
    logic               core_busy = 1'b0;
    logic               core_done = 1'b0;
    logic [HASH_W-1:0]  core_hash = '0;

    hash_host_if #(
        .BUS_W   (BUS_W),
        .BLOCK_W (BLOCK_W),
        .HASH_W  (HASH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .load       (load),
        .fetch      (fetch),
        .idata      (idata),
        .odata      (odata),
        .ack        (ack),
        .core_init  (core_init),
        .core_start (core_start),
        .core_blk   (core_blk),
        .core_busy  (core_busy),
        .core_done  (core_done),
        .core_hash  (core_hash)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               is_fetch;
        logic [BUS_W-1:0] word;
    } exp_t;

    exp_t               exp_q[$];
    logic [BLOCK_W-1:0] blk_q[$];
    logic [BUS_W-1:0]   fill_words[$];
    logic [BUS_W-1:0]   digest_words[$];
    int                 checks = 0;
    int                 failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_block(input logic [BLOCK_W-1:0] req);
        logic [BLOCK_W-1:0] a;
        logic [BLOCK_W-1:0] e;
        int                 idx;
        checks++;
        if (core_blk !== req) begin
            failures++;
            a = core_blk;
            e = req;
            idx = 0;
            while (idx < WPB && a[BLOCK_W-1 -: BUS_W] === e[BLOCK_W-1 -: BUS_W]) begin
                a = a << BUS_W;
                e = e << BUS_W;
                idx++;
            end
            $display("FAIL core_blk word=%0d actual=%h required=%h",
                     idx, a[BLOCK_W-1 -: BUS_W], e[BLOCK_W-1 -: BUS_W]);
        end
    endtask

    task automatic push_exp(input bit is_fetch, input logic [BUS_W-1:0] w);
        exp_t e;
        e.is_fetch = is_fetch;
        e.word     = w;
        exp_q.push_back(e);
    endtask

    // Reference: a block is the WPB loaded words with the first at the top.
    task automatic model_load(input logic [BUS_W-1:0] w);
        logic [BLOCK_W-1:0] b;
        fill_words.push_back(w);
        if (fill_words.size() == WPB) begin
            b = '0;
            foreach (fill_words[i]) b = {b[BLOCK_W-BUS_W-1:0], fill_words[i]};
            blk_q.push_back(b);
            fill_words.delete();
        end
    endtask

    task automatic model_digest(input logic [HASH_W-1:0] h);
        logic [HASH_W-1:0] t;
        t = h;
        digest_words.delete();
        for (int i = 0; i < WPH; i++) begin
            digest_words.push_back(t[HASH_W-1 -: BUS_W]);
            t = t << BUS_W;
        end
    endtask

    function automatic logic [HASH_W-1:0] rand_hash();
        logic [HASH_W-1:0] h;
        h = '0;
        for (int i = 0; i < HASH_W / 32; i++) h = {h[HASH_W-33:0], 32'($urandom())};
        return h;
    endfunction

    // Monitor: every ack must match a queued expectation; fetch acks carry data.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                if (e.is_fetch) check("odata", odata, e.word);
            end
        end
        if (core_start) begin
            if (blk_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_core_start actual=1 required=0");
            end else begin
                check_block(blk_q.pop_front());
            end
        end
    end

    task automatic wait_ack(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
        #1;
        load  = 1'b0;
        fetch = 1'b0;
    endtask

    task automatic do_load(input logic [BUS_W-1:0] w);
        int lat;
        bit completes;
        @(negedge clk);
        completes = (fill_words.size() == WPB - 1);
        push_exp(1'b0, w);
        model_load(w);
        idata = w;
        load  = 1'b1;
        wait_ack(40, lat);
        check("load_ack_latency", lat, 1);
        check("core_start_with_ack", core_start, completes && !core_busy);
    endtask

    task automatic do_fetch();
        int lat;
        @(negedge clk);
        push_exp(1'b1, digest_words.pop_front());
        fetch = 1'b1;
        wait_ack(40, lat);
        check("fetch_ack_latency", lat, 1);
    endtask

    task automatic stall_req(input bit is_fetch, input int n, input string name);
        int acks;
        acks = 0;
        @(negedge clk);
        if (is_fetch) fetch = 1'b1;
        else load = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        #1;
        load  = 1'b0;
        fetch = 1'b0;
        check(name, acks, 0);
    endtask

    task automatic do_init();
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        check("core_init_pulse", core_init, 1);
        fill_words.delete();
        digest_words.delete();
    endtask

    task automatic pulse_done(input logic [HASH_W-1:0] h);
        @(negedge clk);
        core_hash = h;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        model_digest(h);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int               lat;
        int               acks;
        logic [BUS_W-1:0] w;
        logic [HASH_W-1:0] h;

        repeat (3) @(negedge clk);
        check("reset_ack", ack, 0);
        check("reset_odata", odata, 0);
        check("reset_core_init", core_init, 0);
        check("reset_core_start", core_start, 0);
        check("reset_core_blk", |core_blk, 0);
        rst = 1'b0;

        stall_req(1'b0, 10, "load_in_idle_no_ack");

        do_init();
        for (int i = 0; i < WPB; i++) do_load(BUS_W'(i));
        core_busy = 1'b1;

        stall_req(1'b1, 20, "fetch_before_done_no_ack");

`ifdef HASH_HOST_IF_DBUF_EN
        for (int i = 0; i < WPB; i++) do_load(BUS_W'($urandom()));
        @(negedge clk);
        w = BUS_W'($urandom());
        push_exp(1'b0, w);
        model_load(w);
        idata = w;
        load  = 1'b1;
        acks  = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("dbuf_extra_load_stalls", acks, 0);
        core_busy = 1'b0;
        @(negedge clk);
        check("dbuf_start_after_busy_falls", core_start, 1);
        wait_ack(40, lat);
        check("dbuf_extra_load_ack", lat, 1);
`else
        @(negedge clk);
        w = BUS_W'($urandom());
        push_exp(1'b0, w);
        model_load(w);
        idata = w;
        load  = 1'b1;
        acks  = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) acks++;
        end
        check("load_stalls_while_busy", acks, 0);
        core_busy = 1'b0;
        wait_ack(40, lat);
        check("load_ack_after_busy_falls", lat, 1);
        for (int i = 1; i < WPB; i++) do_load(BUS_W'($urandom()));
`endif

        pulse_done({4{64'h0123_4567_89AB_CDEF}});
        do_fetch();
        check("first_digest_word", odata, 16'h0123);
        for (int i = 1; i < WPH; i++) do_fetch();
        check("last_digest_word", odata, 16'hCDEF);
        stall_req(1'b1, 20, "fetch_after_last_word_stalls");

        pulse_done(rand_hash());
        for (int i = 0; i < WPH / 2; i++) do_fetch();
        @(negedge clk);
        h = rand_hash();
        push_exp(1'b1, digest_words.pop_front());
        core_hash = h;
        core_done = 1'b1;
        fetch     = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        check("fetch_with_done_acked", ack, 1);
        #1;
        fetch = 1'b0;
        model_digest(h);
        for (int i = 0; i < WPH; i++) do_fetch();
        stall_req(1'b1, 10, "new_digest_exhausted_stalls");

        do_init();
        for (int i = 0; i < 40; i++) do_load(BUS_W'($urandom()));
        @(negedge clk);
        init  = 1'b1;
        load  = 1'b1;
        idata = BUS_W'($urandom());
        @(negedge clk);
        init = 1'b0;
        load = 1'b0;
        check("load_with_init_no_ack", ack, 0);
        check("core_init_mid_block", core_init, 1);
        fill_words.delete();
        digest_words.delete();
        for (int i = 0; i < WPB; i++) do_load(BUS_W'($urandom()));

        pulse_done(rand_hash());
        for (int i = 0; i < 5; i++) do_fetch();
        @(negedge clk);
        fetch = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        check("rst_ack_zero", ack, 0);
        check("rst_odata_zero", odata, 0);
        check("rst_core_blk_zero", |core_blk, 0);
        rst = 1'b0;
        digest_words.delete();
        fill_words.delete();
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) acks++;
        end
        #1;
        fetch = 1'b0;
        check("fetch_after_rst_stalls", acks, 0);

        repeat (3) @(negedge clk);
        check("ack_queue_drained", exp_q.size(), 0);
        check("block_queue_drained", blk_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_host_if.md
# hash_host_if

Parametrised host-side word interface for the hash cores. It accepts message words over a narrow bus using a level-request/pulse-acknowledge handshake, assembles them into full message blocks, and issues each block to the compression core with a start pulse. It then serialises the captured digest back to the host. It generalises the fixed 16-bit / 256-bit ECHO host interface to arbitrary bus, block and digest widths, and adds optional double buffering so block fill can overlap core compression.

## Interface
Parameters:
- BUS_W, 16, host data bus width in bits.
- BLOCK_W, 1536, message block width; must be a multiple of BUS_W.
- HASH_W, 256, digest width; must be a multiple of BUS_W.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- init  in  1  start of a new message; one-cycle pulse.
- load  in  1  request to write `idata`; level, held until `ack`.
- fetch  in  1  request to read the next digest word; level, held until `ack`.
- idata  in  BUS_W  message word.
- odata  out  BUS_W  digest word; valid in the cycle `ack` is high after a fetch.
- ack  out  1  one-cycle acknowledge for load or fetch.
- core_init  out  1  one-cycle pulse to the core, issued the cycle after `init`.
- core_start  out  1  one-cycle pulse: `core_blk` holds a complete block.
- core_blk  out  BLOCK_W  block presented to the core; stable from `core_start` until `core_busy` falls.
- core_busy  in  1  core is compressing.
- core_done  in  1  one-cycle pulse: `core_hash` is valid.
- core_hash  in  HASH_W  digest from the core.

## Operation
- Derived constants:
  - WPB = BLOCK_W/BUS_W.
  - WPH = HASH_W/BUS_W.
  - Counter widths are $clog2 of each.
- Word order is MSW first. The first loaded word lands in bits [BLOCK_W-1 -: BUS_W]. The first fetched word is core_hash[HASH_W-1 -: BUS_W].
- Handshake:
  - A request is accepted in a cycle where it is high, `ack` is low, and the block is ready.
  - `ack` rises in the next cycle and lasts one cycle.
  - The host must drop the request in the `ack` cycle.
  - No acceptance occurs while `ack` is high, so throughput is at most one word per 2 cycles.
- Priority: `init` > `load` > `fetch`. A load or fetch presented in an `init` cycle is ignored and not acked.
- Fill state machine, states IDLE → FILL → ISSUE → FILL:
  - `init` in any state: clear `wr_cnt`, `rd_cnt`, `hash_valid` and the pending-block flag, then enter FILL.
  - FILL: each accepted load writes word `wr_cnt`. When `wr_cnt` = WPB-1, wrap `wr_cnt` to 0 and enter ISSUE.
  - ISSUE: when `core_busy` is 0, copy the buffer to `core_blk` (in the no-buffer build it is already there), pulse `core_start`, and return to FILL.
  - IDLE is occupied only after reset; loads are not acked in IDLE.
- Stall: a load is not accepted while a completed block has not yet been issued. In the no-buffer build, loads are also not accepted while `core_busy` is 1.
- Digest capture: on `core_done`, register `core_hash`, set `hash_valid`, and set `rd_cnt` to 0.
- Fetch:
  - Accepted only when `hash_valid` is 1; otherwise it stalls.
  - An accepted fetch drives word `rd_cnt` onto `odata` with `ack`.
  - After word WPH-1, clear `hash_valid` and wrap `rd_cnt` to 0. Further fetches stall until the next `core_done`.
- `core_done` coinciding with an accepted fetch: the new digest wins. `rd_cnt` becomes 0, and the acked word comes from the old digest.
- Reset mid-operation discards the partial block and the digest. The core is not notified except through its own reset.

## Timing
- Reset values:
  - Outputs: `ack`=0, `odata`=0, `core_init`=0, `core_start`=0, `core_blk`=0.
  - Internal state: IDLE, counters 0, `hash_valid`=0.
- Load latency: accept at cycle t, `ack` at t+1.
- Issue latency: `core_start` is asserted in the cycle after the last word's acceptance when `core_busy`=0, i.e. coincident with that word's `ack`. Otherwise it is asserted the cycle after `core_busy` falls.
- Fetch latency: accept at t, `ack` and `odata` at t+1. `odata` holds its value until the next fetch ack.
- `core_init` at t+1 for `init` at t.

## Configuration
- HASH_HOST_IF_DBUF_EN defined:
  - A separate fill buffer of BLOCK_W bits exists alongside `core_blk`.
  - The next block fills while the core is busy.
  - Loads stall only when a full block is pending and the core is still busy.
- HASH_HOST_IF_DBUF_EN undefined:
  - `core_blk` is the fill register.
  - Loads stall for the whole `core_busy` period.
  - Area is smaller by BLOCK_W flops.

## Structure
- Shared package `hash_pkg`: fill-state enum (IDLE, FILL, ISSUE) and the default BUS_W/BLOCK_W/HASH_W constants per algorithm.
- One natural sub-module: `hash_host_rd`, the digest capture register, `rd_cnt` and the fetch serialiser. The top owns the fill FSM and the ack arbitration.

## Test plan
- Defaults: reset, `init`, 96 loads of 16'h0000…16'h005F → 96 acks, one `core_start` coincident with the 96th ack, `core_blk`[1535:1520]=16'h0000, `core_blk`[15:0]=16'h005F.
- Fetch before `core_done` → no `ack` for 20 cycles. Then drive `core_done` with `core_hash`=256'h0123…CDEF; 16 fetches → `odata` 16'h0123 first, 16'hCDEF last. A 17th fetch stalls.
- Without DBUF: hold `core_busy`=1 after the first block, attempt a load → no ack until `core_busy` falls, then ack 1 cycle after acceptance.
- With DBUF: 96 more loads during `core_busy`=1 → all acked. The 97th load stalls. `core_start` fires the cycle after `core_busy` falls.
- `init` mid-block after 40 words, together with a load → that load is not acked, `core_init` pulses, and the next 96 words form a clean block (first word at MSW).
- `rst` asserted during a fetch sequence → `odata`=0, `ack`=0 next cycle. A subsequent fetch stalls.
